// File: rtl/divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state
// encoding and the step-counter width helper.
package divider_pkg;

   // Controller states, 2-bit encoding
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Width needed for a counter that holds the values 0..bits
   function automatic int cnt_width(input int bits);
      return $clog2(bits + 1);
   endfunction

endpackage

// File: rtl/divider_step.sv
// One restoring-division iteration: shift {rem, quo} left by one, try to
// subtract the divisor from the widened partial remainder and keep the
// result only when it does not go negative.
module divider_step #(
   parameter int BITS = 4
) (
   input  logic [BITS-1:0] rem,
   input  logic [BITS-1:0] quo,
   input  logic [BITS-1:0] divisor,
   output logic [BITS-1:0] next_rem,
   output logic [BITS-1:0] next_quo
);

   // Partial keeps the bit shifted out of rem so divisors with the MSB set compare correctly
   logic        [BITS:0]   partial;
   logic signed [BITS+1:0] diff;

   // Trial subtraction and restore decision
   always_comb begin
      partial = {rem, quo[BITS-1]};
      diff    = $signed({1'b0, partial}) - $signed({2'b00, divisor});
      // Any set bit above the remainder width means the subtraction borrowed
      if (diff[BITS+1:BITS] == 2'b00) begin
         next_rem = diff[BITS-1:0];
         next_quo = {quo[BITS-2:0], 1'b1};
      end else begin
         next_rem = partial[BITS-1:0];
         next_quo = {quo[BITS-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/divider.sv
// Sequential restoring divider: 2*BITS-bit dividend / BITS-bit divisor,
// one quotient bit per clock. Start/finished handshake matches the
// shift-add multiplier so products can be fed straight back for checking.
module divider #(
   parameter int BITS = 4
) (
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic              i_start,
   output logic              o_busy,
   output logic              o_finished,
   input  logic [2*BITS-1:0] i_dividend,
   input  logic [BITS-1:0]   i_divisor,
   output logic [BITS-1:0]   o_quotient,
   output logic [BITS-1:0]   o_remainder,
   output logic              o_overflow,
   output logic              o_divide_by_zero
);
   import divider_pkg::*;

   localparam int CW = cnt_width(BITS);

   state_t          state;
   state_t          state_nxt;
   logic [CW-1:0]   cnt;
   logic [BITS-1:0] rem;
   logic [BITS-1:0] quo;
   logic [BITS-1:0] dvs;
   logic [BITS-1:0] step_rem;
   logic [BITS-1:0] step_quo;

   logic accept;
   logic err_zero;
   logic err_ovf;
   logic last_step;

   // A start is only honoured when not iterating; zero divisor takes priority over overflow
   assign accept    = i_start && (state == IDLE || state == DONE);
   assign err_zero  = (i_divisor == '0);
   assign err_ovf   = !err_zero && (i_dividend[2*BITS-1:BITS] >= i_divisor);
   assign last_step = (state == RUN) && (cnt == CW'(1));

   divider_step #(
      .BITS(BITS)
   ) u_step (
      .rem     (rem),
      .quo     (quo),
      .divisor (dvs),
      .next_rem(step_rem),
      .next_quo(step_quo)
   );

   // State register
   always_ff @(posedge i_clock) begin
      if (!i_reset) state <= IDLE;
      else          state <= state_nxt;
   end

   // Next-state logic; error operations skip RUN entirely
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (i_start) state_nxt = (err_zero || err_ovf) ? DONE : RUN;
         RUN:  if (last_step) state_nxt = DONE;
         DONE: begin
            if (i_start) state_nxt = (err_zero || err_ovf) ? DONE : RUN;
            else         state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake outputs decoded from state
   always_comb begin
      o_busy     = (state == RUN);
      o_finished = (state == DONE);
   end

   // Step counter: loaded on accept, counts down one per iteration
   always_ff @(posedge i_clock) begin
      if (!i_reset)           cnt <= '0;
      else if (accept)        cnt <= CW'(BITS);
      else if (state == RUN)  cnt <= cnt - CW'(1);
   end

   // Working registers: operands latched on accept, then iterated in RUN
   always_ff @(posedge i_clock) begin
      if (accept) begin
         rem <= i_dividend[2*BITS-1:BITS];
         quo <= i_dividend[BITS-1:0];
         dvs <= i_divisor;
      end else if (state == RUN) begin
         rem <= step_rem;
         quo <= step_quo;
      end
   end

   // Result registers change only on entry to DONE and hold otherwise
   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         o_quotient       <= '0;
         o_remainder      <= '0;
         o_overflow       <= 1'b0;
         o_divide_by_zero <= 1'b0;
      end else if (accept && (err_zero || err_ovf)) begin
         o_quotient       <= '0;
         o_remainder      <= '0;
         o_overflow       <= err_ovf;
         o_divide_by_zero <= err_zero;
      end else if (last_step) begin
         o_quotient       <= step_quo;
         o_remainder      <= step_rem;
         o_overflow       <= 1'b0;
         o_divide_by_zero <= 1'b0;
      end
   end

endmodule

// File: tb/tb_divider.sv
// Directed bench for the restoring divider with BITS=4.
module tb_divider;

   localparam int BITS = 4;

   logic              i_clock;
   logic              i_reset;
   logic              i_start;
   logic              o_busy;
   logic              o_finished;
   logic [2*BITS-1:0] i_dividend;
   logic [BITS-1:0]   i_divisor;
   logic [BITS-1:0]   o_quotient;
   logic [BITS-1:0]   o_remainder;
   logic              o_overflow;
   logic              o_divide_by_zero;

   int n_tests = 0;
   int n_fail  = 0;

   divider #(
      .BITS(BITS)
   ) dut (
      .i_clock         (i_clock),
      .i_reset         (i_reset),
      .i_start         (i_start),
      .o_busy          (o_busy),
      .o_finished      (o_finished),
      .i_dividend      (i_dividend),
      .i_divisor       (i_divisor),
      .o_quotient      (o_quotient),
      .o_remainder     (o_remainder),
      .o_overflow      (o_overflow),
      .o_divide_by_zero(o_divide_by_zero)
   );

   initial i_clock = 1'b0;
   always #5 i_clock = ~i_clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Accept an operation, then wait (bounded) for the finished pulse.
   // lat = edges after the accepting edge until o_finished is seen.
   task automatic do_op(input logic [7:0] dd, input logic [3:0] dv,
                        output logic busy_after_accept, output int lat);
      i_dividend = dd;
      i_divisor  = dv;
      i_start    = 1'b1;
      @(posedge i_clock); #1;
      i_start = 1'b0;
      busy_after_accept = o_busy;
      lat = 0;
      while (o_finished !== 1'b1 && lat < 20) begin
         @(posedge i_clock); #1;
         lat++;
      end
   endtask

   initial begin
      logic b;
      int   lat;
      int   pulses;

      // Reset held low for two edges with start asserted
      i_reset    = 1'b0;
      i_start    = 1'b1;
      i_dividend = 8'd55;
      i_divisor  = 4'd5;
      @(posedge i_clock);
      @(posedge i_clock); #1;
      check("rst_quotient",  o_quotient,       0);
      check("rst_remainder", o_remainder,      0);
      check("rst_overflow",  o_overflow,       0);
      check("rst_dbz",       o_divide_by_zero, 0);
      check("rst_busy",      o_busy,           0);
      check("rst_finished",  o_finished,       0);
      i_reset = 1'b1;
      i_start = 1'b0;
      @(posedge i_clock); #1;

      // 55 / 5 = 11 r 0
      do_op(8'd55, 4'd5, b, lat);
      check("55_5_busy",  b,                1);
      check("55_5_lat",   lat,              4);
      check("55_5_quo",   o_quotient,       11);
      check("55_5_rem",   o_remainder,      0);
      check("55_5_ovf",   o_overflow,       0);
      check("55_5_dbz",   o_divide_by_zero, 0);
      @(posedge i_clock); #1;
      check("55_5_fin_drop", o_finished,    0);
      check("55_5_hold_quo", o_quotient,    11);

      // 100 / 7 = 14 r 2
      do_op(8'd100, 4'd7, b, lat);
      check("100_7_lat", lat,         4);
      check("100_7_quo", o_quotient,  14);
      check("100_7_rem", o_remainder, 2);

      // 143 / 13 = 11 r 0, divisor MSB set
      do_op(8'd143, 4'd13, b, lat);
      check("143_13_lat", lat,         4);
      check("143_13_quo", o_quotient,  11);
      check("143_13_rem", o_remainder, 0);

      // 200 / 5 overflows
      do_op(8'd200, 4'd5, b, lat);
      check("200_5_busy", b,                0);
      check("200_5_lat",  lat,              0);
      check("200_5_ovf",  o_overflow,       1);
      check("200_5_dbz",  o_divide_by_zero, 0);
      check("200_5_quo",  o_quotient,       0);
      check("200_5_rem",  o_remainder,      0);
      @(posedge i_clock); #1;
      check("200_5_fin_drop", o_finished, 0);

      // 20 / 0 divide by zero takes priority
      do_op(8'd20, 4'd0, b, lat);
      check("20_0_lat", lat,              0);
      check("20_0_dbz", o_divide_by_zero, 1);
      check("20_0_ovf", o_overflow,       0);
      check("20_0_quo", o_quotient,       0);
      check("20_0_rem", o_remainder,      0);

      // Back-to-back with start held: 130/10 then 55/5
      @(posedge i_clock); #1;
      i_dividend = 8'd130;
      i_divisor  = 4'd10;
      i_start    = 1'b1;
      @(posedge i_clock); #1;
      i_dividend = 8'd55;
      i_divisor  = 4'd5;
      lat = 0;
      while (o_finished !== 1'b1 && lat < 20) begin
         @(posedge i_clock); #1;
         lat++;
      end
      check("b2b_first_lat", lat,         4);
      check("b2b_first_quo", o_quotient,  13);
      check("b2b_first_rem", o_remainder, 0);
      lat = 0;
      do begin
         @(posedge i_clock); #1;
         lat++;
      end while (o_finished !== 1'b1 && lat < 20);
      i_start = 1'b0;
      check("b2b_spacing",    lat,         5);
      check("b2b_second_quo", o_quotient,  11);
      check("b2b_second_rem", o_remainder, 0);
      @(posedge i_clock); #1;

      // Reset asserted at step 2 discards the operation
      i_dividend = 8'd100;
      i_divisor  = 4'd7;
      i_start    = 1'b1;
      @(posedge i_clock); #1;
      i_start = 1'b0;
      @(posedge i_clock); #1;
      i_reset = 1'b0;
      @(posedge i_clock); #1;
      check("rstrun_busy",     o_busy,      0);
      check("rstrun_finished", o_finished,  0);
      check("rstrun_quo",      o_quotient,  0);
      check("rstrun_rem",      o_remainder, 0);
      i_reset = 1'b1;
      pulses = 0;
      for (int k = 0; k < 8; k++) begin
         @(posedge i_clock); #1;
         if (o_finished === 1'b1) pulses++;
      end
      check("rstrun_no_pulse", pulses, 0);

      // Exhaustive in-range sweep against the arithmetic definition
      for (int dv = 1; dv < 16; dv++) begin
         for (int dd = 0; dd < 16 * dv; dd++) begin
            do_op(dd[7:0], dv[3:0], b, lat);
            check($sformatf("sweep_quo_%0d_%0d", dd, dv), o_quotient,  dd / dv);
            check($sformatf("sweep_rem_%0d_%0d", dd, dv), o_remainder, dd % dv);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
